// File: rtl/uart_ctrl_tx_if.sv
// User-side request/ready handshake of the UART transmitter.
interface uart_ctrl_tx_if;
    logic       start;
    logic [7:0] data;
    logic       ready;

    modport master (output start, output data, input ready);
    modport slave  (input start, input data, output ready);
endinterface

// File: rtl/uart_ctrl_tx.sv
// UART transmitter: one 8N1 frame per accepted request, bit timing from an internal baud counter.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_ctrl_tx #(
    parameter int unsigned BAUDRATE = 104
) (
    input  logic          clk,
    input  logic          rst,
    uart_ctrl_tx_if.slave bus,
    output logic          tx
);

`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    localparam int unsigned BAUD_W = $clog2(BAUDRATE);
    localparam int unsigned BIT_W  = 4;
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(BAUDRATE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, TRANS, DONE} state_e;

    state_e                  state_q;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [BAUD_W-1:0]       baud_q;
    logic [BIT_W-1:0]        bit_q;
    logic                    tx_q;
    logic                    ready_q;
    logic [FRAME_BITS-1:0]   frame_c;

    // Frame image, LSB goes out first: start bit, data, [parity], stop bit.
`ifdef UART_TX_PARITY_EN
    assign frame_c = {1'b1, ^bus.data, bus.data, 1'b0};
`else
    assign frame_c = {1'b1, bus.data, 1'b0};
`endif

    // tx_q always holds the level for the next cycle so the pin is purely registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '1;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    if (bus.start) begin
                        shift_q <= frame_c;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= TRANS;
                    end
                end
                TRANS: begin
                    if (baud_q == BAUD_MAX) begin
                        baud_q  <= '0;
                        shift_q <= {1'b1, shift_q[FRAME_BITS-1:1]};
                        bit_q   <= bit_q + BIT_W'(1);
                        if (bit_q == LAST_BIT) begin
                            tx_q    <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                DONE: begin
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx        = tx_q;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_uart_ctrl_tx.sv
// Self-checking bench for uart_ctrl_tx: directed frames plus random traffic against a frame-timing model.
module tb_uart_ctrl_tx;
    localparam int B = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;

    uart_ctrl_tx_if bus_if ();

    uart_ctrl_tx #(.BAUDRATE(B)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   n_acc    = -1;
    logic frame [11];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Model: a frame accepted in cycle N drives bit k over cycles N+1+k*B .. N+(k+1)*B,
    // then one busy idle-high cycle, then ready again.
    task automatic step();
        logic       exp_tx;
        logic       exp_rdy;
        logic [7:0] d;
        int         off;
        @(negedge clk);
        exp_tx  = 1'b1;
        exp_rdy = 1'b1;
        if (rst) begin
            n_acc = -1;
        end else if (n_acc >= 0) begin
            off = cyc - n_acc;
            if (off >= 1 && off <= FB * B) begin
                exp_rdy = 1'b0;
                exp_tx  = frame[(off - 1) / B];
            end else if (off == FB * B + 1) begin
                exp_rdy = 1'b0;
            end
        end
        check_eq("tx", 32'(tx), 32'(exp_tx));
        check_eq("ready", 32'(bus_if.ready), 32'(exp_rdy));
        if (!rst && bus_if.start && exp_rdy) begin
            n_acc = cyc;
            d = bus_if.data;
            frame[0] = 1'b0;
            for (int i = 0; i < 8; i++) frame[i + 1] = d[i];
`ifdef UART_TX_PARITY_EN
            frame[9]  = ^d;
            frame[10] = 1'b1;
`else
            frame[9]  = 1'b1;
            frame[10] = 1'b1;
`endif
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) begin
            bus_if.data = 8'($urandom);
            step();
        end
    endtask

    task automatic send(input logic [7:0] d);
        bus_if.start = 1'b1;
        bus_if.data  = d;
        step();
        bus_if.start = 1'b0;
    endtask

    initial begin
        bus_if.start = 1'b0;
        bus_if.data  = 8'h00;
        rst          = 1'b1;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        idle_steps(50);

        send(8'h55);
        idle_steps(FB * B + 5);

        // start held high: two frames back to back, data changes only at accept
        bus_if.start = 1'b1;
        bus_if.data  = 8'hA3;
        step();
        bus_if.data = 8'hFF;
        for (int i = 0; i < FB * B + 1; i++) step();
        bus_if.data = 8'h3C;
        for (int i = 0; i < 5; i++) step();
        bus_if.start = 1'b0;
        idle_steps(FB * B + 5);

        // request during a frame must be dropped
        send(8'hAB);
        idle_steps(15);
        send(8'h00);
        idle_steps(FB * B + 10);

        // async reset in the 3rd cycle of data bit 2 (data bit 2 is 0, so tx must jump)
        send(8'hFB);
        idle_steps(3 * B + 2);
        rst = 1'b1;
        #1;
        check_eq("async_rst_tx", 32'(tx), 32'd1);
        check_eq("async_rst_ready", 32'(bus_if.ready), 32'd1);
        step();
        rst = 1'b0;
        idle_steps(FB * B + 10);

        // start together with reset must not launch a frame
        rst          = 1'b1;
        bus_if.start = 1'b1;
        bus_if.data  = 8'h81;
        step();
        rst          = 1'b0;
        bus_if.start = 1'b0;
        idle_steps(20);

        send(8'h07);
        idle_steps(FB * B + 5);

        for (int i = 0; i < 3000; i++) begin
            bus_if.start = ($urandom_range(0, 3) == 0);
            bus_if.data  = 8'($urandom);
            rst          = ($urandom_range(0, 199) == 0);
            step();
        end
        rst          = 1'b0;
        bus_if.start = 1'b0;
        idle_steps(FB * B + 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
